// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register select, data word and queued load entry.
package wb_arbiter_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned WB_DEPTH = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef struct packed {
    regbits_t wsel;
    word_t    wdat;
  } wb_entry_t;

  // Occupancy counter width; one extra bit so a full queue is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU/load producers and issue side in, register-file port and status out.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned REGS  = NUM_REGS
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic             alu_wen;
  regbits_t         alu_wsel;
  word_t            alu_wdat;
  logic             ld_valid;
  regbits_t         ld_wsel;
  word_t            ld_wdat;
  logic             ld_ready;
  logic             issue_ld;
  regbits_t         issue_wsel;
  logic [REGS-1:0]  busy;
  logic             WEN;
  regbits_t         wsel;
  word_t            wdat;
  logic [CNT_W-1:0] count;
  logic             ovf_err;

  modport slave (
    input  alu_wen, alu_wsel, alu_wdat,
    input  ld_valid, ld_wsel, ld_wdat,
    input  issue_ld, issue_wsel,
    output ld_ready, busy, WEN, wsel, wdat, count, ovf_err
  );

  modport master (
    output alu_wen, alu_wsel, alu_wdat,
    output ld_valid, ld_wsel, ld_wdat,
    output issue_ld, issue_wsel,
    input  ld_ready, busy, WEN, wsel, wdat, count, ovf_err
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// In-order circular queue of load results; ready is registered and reflects only the stored count.
module wb_arbiter_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  wb_entry_t                      din,
  output wb_entry_t                      head,
  output logic [cnt_width(DEPTH)-1:0]    count,
  output logic                           ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ready_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d < CNT_W'(DEPTH));
    end
  end

  assign head  = mem[head_ptr];
  assign count = count_q;
  assign ready = ready_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto one register-file write port,
// queuing colliding loads and tracking outstanding loads per register.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned REGS  = NUM_REGS
) (
  input  logic         CLK,
  input  logic         RST,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic             alu_take;
  logic             ld_take;
  logic             fifo_empty;
  logic             fifo_ready;
  logic             push;
  logic             pop;
  logic             bypass;
  wb_entry_t        fifo_head;
  wb_entry_t        fifo_din;
  logic [CNT_W-1:0] fifo_count;

  logic             wen_q;
  logic             wen_ld_q;
  regbits_t         wsel_q;
  word_t            wdat_q;
  logic             ovf_q;
  logic [REGS-1:0]  busy_q;
  logic [REGS-1:0]  busy_d;

  // Port select: ALU first, then queue head, then a load bypass when the queue is empty.
  always_comb begin
    alu_take   = 1'b0;
    ld_take    = 1'b0;
    pop        = 1'b0;
    bypass     = 1'b0;
    push       = 1'b0;
    fifo_empty = (fifo_count == CNT_W'(0));

    alu_take = bus.alu_wen  && (bus.alu_wsel != '0);
    ld_take  = bus.ld_valid && (bus.ld_wsel  != '0);
    pop      = !alu_take && !fifo_empty;
    bypass   = !alu_take && fifo_empty && ld_take;
    push     = ld_take && fifo_ready && !bypass;
  end

  assign fifo_din = '{wsel: bus.ld_wsel, wdat: bus.ld_wdat};

  wb_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .count (fifo_count),
    .ready (fifo_ready)
  );

  // Clear lands one edge after the load's write cycle; a same-edge issue re-sets the bit.
  always_comb begin
    busy_d = busy_q;
    if (wen_q && wen_ld_q) busy_d[wsel_q] = 1'b0;
    if (bus.issue_ld && (bus.issue_wsel != '0)) busy_d[bus.issue_wsel] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wen_q    <= 1'b0;
      wen_ld_q <= 1'b0;
      wsel_q   <= '0;
      wdat_q   <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= '0;
    end else begin
      if (alu_take) begin
        wen_q    <= 1'b1;
        wen_ld_q <= 1'b0;
        wsel_q   <= bus.alu_wsel;
        wdat_q   <= bus.alu_wdat;
      end else if (pop) begin
        wen_q    <= 1'b1;
        wen_ld_q <= 1'b1;
        wsel_q   <= fifo_head.wsel;
        wdat_q   <= fifo_head.wdat;
      end else if (bypass) begin
        wen_q    <= 1'b1;
        wen_ld_q <= 1'b1;
        wsel_q   <= bus.ld_wsel;
        wdat_q   <= bus.ld_wdat;
      end else begin
        wen_q    <= 1'b0;
        wen_ld_q <= 1'b0;
      end
      if (bus.ld_valid && !fifo_ready) ovf_q <= 1'b1;
      busy_q <= busy_d;
    end
  end

  assign bus.WEN      = wen_q;
  assign bus.wsel     = wsel_q;
  assign bus.wdat     = wdat_q;
  assign bus.busy     = busy_q;
  assign bus.count    = fifo_count;
  assign bus.ld_ready = fifo_ready;
  assign bus.ovf_err  = ovf_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic CLK;
  logic RST;
  int   chk_cnt;
  int   err_cnt;

  wb_arbiter_if #(.DEPTH(4), .REGS(32)) bus ();

  wb_arbiter #(.DEPTH(4), .REGS(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.alu_wen    = 1'b0;
    bus.alu_wsel   = '0;
    bus.alu_wdat   = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_wsel    = '0;
    bus.ld_wdat    = '0;
    bus.issue_ld   = 1'b0;
    bus.issue_wsel = '0;
  endtask

  task automatic alu(input int r, input logic [31:0] d);
    bus.alu_wen  = 1'b1;
    bus.alu_wsel = 5'(r);
    bus.alu_wdat = d;
  endtask

  task automatic ld(input int r, input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_wsel  = 5'(r);
    bus.ld_wdat  = d;
  endtask

  task automatic issue(input int r);
    bus.issue_ld   = 1'b1;
    bus.issue_wsel = 5'(r);
  endtask

  task automatic chk_wr(input string tag, input int r, input logic [31:0] d);
    chk({tag, "_wen"}, 32'(bus.WEN), 32'd1);
    chk({tag, "_wsel"}, 32'(bus.wsel), 32'(r));
    chk({tag, "_wdat"}, bus.wdat, d);
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    idle();

    // Reset with traffic on every input
    RST = 1'b1;
    alu(1, 32'h1);
    ld(2, 32'h2);
    issue(3);
    tick();
    tick();
    chk("rst_wen", 32'(bus.WEN), 32'd0);
    chk("rst_wsel", 32'(bus.wsel), 32'd0);
    chk("rst_wdat", bus.wdat, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ready", 32'(bus.ld_ready), 32'd1);
    chk("rst_ovf", 32'(bus.ovf_err), 32'd0);
    RST = 1'b0;
    idle();
    tick();
    chk("post_rst_wen", 32'(bus.WEN), 32'd0);

    // Bypass
    ld(5, 32'hDEAD_BEEF);
    tick();
    chk_wr("byp", 5, 32'hDEAD_BEEF);
    chk("byp_count", 32'(bus.count), 32'd0);
    idle();
    tick();
    chk("byp_idle_wen", 32'(bus.WEN), 32'd0);

    // Collision
    alu(3, 32'h11);
    ld(4, 32'h22);
    tick();
    chk_wr("col_alu", 3, 32'h11);
    chk("col_count1", 32'(bus.count), 32'd1);
    idle();
    tick();
    chk_wr("col_ld", 4, 32'h22);
    chk("col_count0", 32'(bus.count), 32'd0);
    tick();
    chk("col_idle_wen", 32'(bus.WEN), 32'd0);

    // Fill, then overflow
    for (int i = 0; i < 4; i++) begin
      alu(1, 32'(i));
      ld(8 + i, 32'h80 + 32'(i));
      tick();
      chk_wr("fill_alu", 1, 32'(i));
      chk("fill_count", 32'(bus.count), 32'(i + 1));
    end
    chk("full_ready", 32'(bus.ld_ready), 32'd0);
    chk("full_ovf_pre", 32'(bus.ovf_err), 32'd0);
    alu(1, 32'h99);
    ld(12, 32'hC0);
    tick();
    chk_wr("ovf_alu", 1, 32'h99);
    chk("ovf_count", 32'(bus.count), 32'd4);
    chk("ovf_err", 32'(bus.ovf_err), 32'd1);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_wr("drain", 8 + i, 32'h80 + 32'(i));
      chk("drain_count", 32'(bus.count), 32'(3 - i));
    end
    tick();
    chk("drain_end_wen", 32'(bus.WEN), 32'd0);
    chk("ovf_sticky", 32'(bus.ovf_err), 32'd1);

    // Scoreboard set/clear
    issue(7);
    tick();
    chk("sb_set", bus.busy, 32'h0000_0080);
    idle();
    ld(7, 32'h77);
    tick();
    chk_wr("sb_wr", 7, 32'h77);
    chk("sb_busy_in_wen", bus.busy, 32'h0000_0080);
    idle();
    tick();
    chk("sb_clear", bus.busy, 32'd0);

    // Same-edge set and clear: set wins
    issue(7);
    tick();
    idle();
    ld(7, 32'h78);
    tick();
    chk_wr("sb2_wr", 7, 32'h78);
    idle();
    issue(7);
    tick();
    chk("sb2_setwins", bus.busy, 32'h0000_0080);
    idle();
    tick();
    chk("sb2_hold", bus.busy, 32'h0000_0080);

    // ALU write leaves busy alone
    alu(7, 32'h55);
    tick();
    chk_wr("sb_alu", 7, 32'h55);
    idle();
    tick();
    chk("sb_alu_busy", bus.busy, 32'h0000_0080);
    ld(7, 32'h79);
    tick();
    idle();
    tick();
    chk("sb_final_clear", bus.busy, 32'd0);

    // Register 0 is discarded everywhere
    alu(0, 32'hAAAA);
    ld(0, 32'hBBBB);
    issue(0);
    tick();
    chk("r0_wen", 32'(bus.WEN), 32'd0);
    chk("r0_count", 32'(bus.count), 32'd0);
    chk("r0_busy", bus.busy, 32'd0);
    idle();

    // Reset mid-operation discards queued loads
    for (int i = 0; i < 2; i++) begin
      alu(1, 32'h10);
      ld(13 + i, 32'hE0);
      issue(20);
      tick();
    end
    chk("mid_count", 32'(bus.count), 32'd2);
    idle();
    RST = 1'b1;
    tick();
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_wen", 32'(bus.WEN), 32'd0);
    chk("mid_rst_busy", bus.busy, 32'd0);
    chk("mid_rst_ovf", 32'(bus.ovf_err), 32'd0);
    RST = 1'b0;
    tick();
    chk("mid_after_wen", 32'(bus.WEN), 32'd0);
    tick();
    chk("mid_after_wen2", 32'(bus.WEN), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
